// File: rtl/common.sv
// common: shared bus, memory-port and arbiter types
package common;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mreq_t;
  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } mresp_t;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  localparam logic [2:0] MSIZE_WORD = 3'b010;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating wait counter with sticky timeout flag
module arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic err_timeout
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] wd;
  always_ff @(posedge clk)
    if (reset) begin
      wd <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (start) wd <= '0;
      else if (active && !ready && wd != '1) wd <= wd + 1'b1;
      if (active && !ready && wd == W'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: alternating ibus/dbus arbiter onto one single-beat memory port
module mem_port_arbiter
  import common::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mreq_t      mreq,
  input  mresp_t     mresp,
  output logic       busy,
  output logic       err_timeout
);
  arb_state_t state, state_n;
  logic last_d, grant_d, start, done, i_ok, d_ok;
  mreq_t lat, lat_n;
  always_comb begin
    grant_d = dreq.valid && (!ireq.valid || !last_d);
    start = state == IDLE && (ireq.valid || dreq.valid);
    done = state != IDLE && mresp.ready;
    state_n = start ? (grant_d ? SERVE_D : SERVE_I) : done ? IDLE : state;
    lat_n = '0;
    lat_n.is_write = grant_d && |dreq.strobe;
    lat_n.size = grant_d ? dreq.size : MSIZE_WORD;
    lat_n.addr = grant_d ? dreq.addr : ireq.addr;
    lat_n.strobe = grant_d ? dreq.strobe : '0;
    lat_n.data = grant_d ? dreq.data : '0;
    i_ok = state == SERVE_I && mresp.ready && ireq.valid && ireq.addr == lat.addr;
    d_ok = state == SERVE_D && mresp.ready && dreq.valid && dreq.addr == lat.addr;
    mreq = lat;
    mreq.valid = state != IDLE;
    iresp.addr_ok = i_ok;
    iresp.data_ok = i_ok;
    iresp.data = state == SERVE_I ? (lat.addr[2] ? mresp.data[63:32] : mresp.data[31:0]) : '0;
    dresp.addr_ok = d_ok;
    dresp.data_ok = d_ok;
    dresp.data = state == SERVE_D ? mresp.data : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b0;
      lat <= '0;
    end else begin
      state <= state_n;
      if (start) lat <= lat_n;
      if (done) last_d <= state == SERVE_D;
    end
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .start(start),
    .active(busy),
    .ready(mresp.ready),
    .err_timeout(err_timeout)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks against a transaction-level model
module tb_mem_port_arbiter;
  import common::*;
  localparam int TIMEOUT = 8;
  logic clk, reset, busy, err_timeout;
  ibus_req_t ireq;
  ibus_resp_t iresp;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  mreq_t mreq;
  mresp_t mresp;
  int checks = 0, errors = 0;
  bit m_busy, m_d, m_prev_d, m_err, m_wr, e_iok, e_dok, pv, ip, dp;
  int m_wait, vcnt, icnt, dcnt;
  logic [63:0] m_addr, m_data;
  logic [7:0] m_strobe;
  logic [2:0] m_size;
  logic [31:0] last_idata;
  logic [63:0] grants[$];
  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp),
    .mreq(mreq), .mresp(mresp), .busy(busy), .err_timeout(err_timeout)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check();
    logic [31:0] iw;
    e_iok = m_busy && mresp.ready && !m_d && ireq.valid && ireq.addr == m_addr;
    e_dok = m_busy && mresp.ready && m_d && dreq.valid && dreq.addr == m_addr;
    chk("mreq.valid", 64'(mreq.valid), 64'(m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    chk("iresp.ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'({e_iok, e_iok}));
    chk("dresp.ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'({e_dok, e_dok}));
    if (m_busy) begin
      chk("mreq.addr", mreq.addr, m_addr);
      chk("mreq.size", 64'(mreq.size), 64'(m_size));
      chk("mreq.strobe", 64'(mreq.strobe), 64'(m_strobe));
      chk("mreq.data", mreq.data, m_data);
      chk("mreq.is_write", 64'(mreq.is_write), 64'(m_wr));
    end
    iw = m_addr[2] ? mresp.data[63:32] : mresp.data[31:0];
    if (e_iok) chk("iresp.data", 64'(iresp.data), 64'(iw));
    else if (!(m_busy && !m_d)) chk("iresp.data idle", 64'(iresp.data), 64'h0);
    if (e_dok) chk("dresp.data", dresp.data, mresp.data);
    else if (!(m_busy && m_d)) chk("dresp.data idle", dresp.data, 64'h0);
    if (mreq.valid) vcnt++;
    if (mreq.valid && !pv) grants.push_back(mreq.addr);
    pv = mreq.valid;
    if (iresp.data_ok) begin
      icnt++;
      last_idata = iresp.data;
    end
    if (dresp.data_ok) dcnt++;
  endtask
  task automatic update();
    if (reset) begin
      m_busy = 0;
      m_prev_d = 0;
      m_err = 0;
      m_wait = 0;
    end else if (m_busy) begin
      if (mresp.ready) begin
        m_busy = 0;
        m_prev_d = m_d;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1;
      end
    end else if (ireq.valid || dreq.valid) begin
      m_d = dreq.valid && !(ireq.valid && m_prev_d);
      m_addr = m_d ? dreq.addr : ireq.addr;
      m_size = m_d ? dreq.size : 3'b010;
      m_strobe = m_d ? dreq.strobe : 8'h0;
      m_data = m_d ? dreq.data : 64'h0;
      m_wr = m_d && dreq.strobe != 0;
      m_wait = 0;
      m_busy = 1;
    end
  endtask
  task automatic cycle();
    #1 check();
    @(posedge clk);
    update();
    #1;
  endtask
  initial begin
    reset = 1;
    ireq = '0;
    dreq = '0;
    mresp = '0;
    @(posedge clk);
    update();
    #1;
    cycle();
    reset = 0;
    vcnt = 0; icnt = 0;
    ireq.valid = 1; ireq.addr = 64'h8000_0004;
    mresp.data = 64'h1111_2222_3333_4444;
    repeat (3) cycle();
    mresp.ready = 1;
    cycle();
    ireq.valid = 0; mresp.ready = 0;
    cycle();
    chk("fetch valid cycles", 64'(vcnt), 64'd3);
    chk("fetch data_ok count", 64'(icnt), 64'd1);
    chk("fetch data word", 64'(last_idata), 64'h1111_2222);
    reset = 1;
    cycle();
    reset = 0;
    grants.delete();
    ireq.valid = 1; ireq.addr = 64'h8000_1000;
    dreq.valid = 1; dreq.addr = 64'h8000_2000; dreq.strobe = 0; dreq.size = 3'b011;
    mresp.ready = 1;
    repeat (8) cycle();
    ireq.valid = 0; dreq.valid = 0; mresp.ready = 0;
    cycle();
    chk("tie grant count", 64'(grants.size()), 64'd4);
    if (grants.size() == 4) begin
      chk("tie grant 0 dbus", grants[0], 64'h8000_2000);
      chk("tie grant 1 ibus", grants[1], 64'h8000_1000);
      chk("tie grant 2 dbus", grants[2], 64'h8000_2000);
      chk("tie grant 3 ibus", grants[3], 64'h8000_1000);
    end
    dcnt = 0;
    dreq.valid = 1; dreq.addr = 64'h8000_0100; dreq.strobe = 8'h0F;
    dreq.data = 64'hDEAD_BEEF; dreq.size = 3'b010;
    cycle();
    mresp.ready = 1;
    #1;
    chk("store is_write", 64'(mreq.is_write), 64'd1);
    chk("store addr", mreq.addr, 64'h8000_0100);
    chk("store data", mreq.data, 64'hDEAD_BEEF);
    chk("store strobe", 64'(mreq.strobe), 64'h0F);
    cycle();
    dreq.valid = 0; mresp.ready = 0;
    cycle();
    chk("store data_ok count", 64'(dcnt), 64'd1);
    icnt = 0;
    ireq.valid = 1; ireq.addr = 64'h8000_0000;
    cycle();
    ireq.addr = 64'h8000_0040; mresp.ready = 1;
    cycle();
    mresp.ready = 0;
    cycle();
    #1;
    chk("stale regrant addr", mreq.addr, 64'h8000_0040);
    mresp.ready = 1;
    cycle();
    ireq.valid = 0; mresp.ready = 0;
    cycle();
    chk("stale data_ok count", 64'(icnt), 64'd1);
    dcnt = 0;
    dreq.valid = 1; dreq.addr = 64'h8000_0200; dreq.strobe = 0;
    cycle();
    repeat (7) cycle();
    #1 chk("watchdog before limit", 64'(err_timeout), 64'd0);
    cycle();
    #1 chk("watchdog raised", 64'(err_timeout), 64'd1);
    mresp.ready = 1;
    cycle();
    dreq.valid = 0; mresp.ready = 0;
    cycle();
    chk("watchdog sticky", 64'(err_timeout), 64'd1);
    chk("watchdog data_ok count", 64'(dcnt), 64'd1);
    dcnt = 0;
    dreq.valid = 1; dreq.addr = 64'h8000_0300;
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0; dreq.valid = 0;
    #1;
    chk("midreset valid", 64'(mreq.valid), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset err", 64'(err_timeout), 64'd0);
    cycle();
    chk("midreset data_ok count", 64'(dcnt), 64'd0);
    ip = 0; dp = 0; e_iok = 0; e_dok = 0;
    repeat (600) begin
      if (ip && e_iok) ip = 0;
      if (dp && e_dok) dp = 0;
      if (!ip) begin
        ireq.valid = 1'($urandom_range(1));
        ireq.addr = {32'h8000_0000, $urandom} & ~64'h3;
        ip = ireq.valid;
      end else if ($urandom_range(15) == 0) ireq.addr ^= 64'h40;
      if (!dp) begin
        dreq.valid = 1'($urandom_range(1));
        dreq.addr = {32'h8000_0000, $urandom} & ~64'h7;
        dreq.size = 3'($urandom_range(3));
        dreq.strobe = $urandom_range(1) ? 8'($urandom) : 8'h0;
        dreq.data = {$urandom, $urandom};
        dp = dreq.valid;
      end
      mresp.ready = $urandom_range(2) == 0;
      mresp.data = {$urandom, $urandom};
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-beat memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between `core` and the memory/MMIO side.
- Latches the winning request, holds it on the shared port until memory accepts, then routes the response back to the requester as a one-cycle `addr_ok`/`data_ok`.
- Grants alternate between the two buses when both are requesting; a watchdog flags a memory port that never responds.

## Interface
- `TIMEOUT`, 1024: cycles a granted transaction may wait for `mresp.ready` before `err_timeout` sets.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ireq` in `ibus_req_t`: fetch request (`valid`, `addr`).
- `iresp` out `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `dreq` in `dbus_req_t`: data request (`valid`, `addr`, `size`, `strobe`, `data`).
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data[63:0]`.
- `mreq` out `mreq_t`: `valid`, `is_write`, `size[2:0]`, `addr[63:0]`, `strobe[7:0]`, `data[63:0]`.
- `mresp` in `mresp_t`: `ready`, `data[63:0]`.
- `busy` out 1: state ≠ IDLE.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, SERVE_I, SERVE_D. Register `last_d` records which bus was served last; reset value 0, so dbus wins the first tie.
- **IDLE, grant selection:**
  - Only `dreq.valid` is high → SERVE_D.
  - Only `ireq.valid` is high → SERVE_I.
  - Both high → SERVE_I if `last_d`=1, else SERVE_D.
  - Neither high → stay in IDLE.
- **Latch on grant:** the winner's fields are copied into the latch register in the same edge as the state change.
  - ibus grant: `size`=3'b010, `strobe`=0, `is_write`=0.
  - dbus grant: `is_write` = |`strobe`.
- **Driving the port:** `mreq` is driven only from the latch; `mreq.valid` = (state ≠ IDLE). Fields are stable while valid.
- **Completion:** in SERVE_x with `mresp.ready`=1:
  - Next state is IDLE; `last_d` is updated.
  - Response goes to the requester combinationally in the same cycle, as `addr_ok`=`data_ok`=1 for exactly that cycle.
  - ibus data is `mresp.data` word-selected by `addr[2]` (high word when 1).
  - dbus data is `mresp.data` unmodified.
- **Stale response:** if at completion the requester's `valid`=0, or its `addr` ≠ latched `addr`, the memory transaction still completes but `addr_ok`/`data_ok` are suppressed. This covers the core redirecting its PC mid-fetch. Writes are never cancelled.
- **Watchdog:**
  - Counter `wd` clears on every grant and increments each SERVE cycle without `ready`.
  - When `wd` = TIMEOUT−1 and `ready`=0, `err_timeout` sets. It clears only on `reset`.
  - The transaction keeps waiting; it is not aborted.
- **Responses while not serving:** `iresp`/`dresp` `ok` bits are 0 whenever the bus is not being served, and both data buses are 0 then.

## Timing
- **Reset values:** state=IDLE, `last_d`=0, `wd`=0, `err_timeout`=0, latch=0. Hence `mreq.valid`=0, `busy`=0, all `ok` bits 0.
- **Latency:** request sampled at edge T → `mreq.valid` from cycle T+1. If `ready` is high in cycle T+1, `data_ok` is in cycle T+1. Minimum request-to-`data_ok` is 1 cycle.
- **Turnaround:** one mandatory IDLE cycle after each completion. Back-to-back transactions issue at most one per 2 cycles.
- **Requester obligation:** hold `valid`/`addr`/`data` stable until `data_ok`. A deviation follows the stale-response rule.
- **Simultaneous events:** `ready` and new requests in the same cycle → the new requests are considered only in the next (IDLE) cycle, using the updated `last_d`.
- **Reset mid-transaction:** returns to IDLE at that edge and drops the in-flight transaction. The memory side is reset by the same signal.
- **Width rules:** `wd` is $clog2(TIMEOUT)+1 bits and saturates; it never wraps.

## Structure
- **Package `common`:**
  - Add `mreq_t` and `mresp_t`.
  - Add `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - Add constant `MSIZE_WORD`=3'b010.
- Existing `ibus_*`/`dbus_*` types are reused unchanged.
- **Sub-module:** one, `arb_watchdog` (counter + sticky flag; inputs `start`, `active`, `ready`).
- Everything else lives in one file, ~200 lines.

## Test plan
- **Lone fetch:** ireq `addr`=0x8000_0004, `ready` after 3 cycles with data 0x1111_2222_3333_4444 → `mreq.valid` high 3 cycles, `is_write`=0, `size`=010; `iresp.data_ok` one cycle with data 0x1111_2222.
- **Tie after reset:** both valid → dbus served first. ireq stays valid → ibus served next, after a one-cycle IDLE gap. Repeat tie → order alternates D, I, D, I.
- **Store:** `dreq` `strobe`=8'h0F, `data`=0xDEAD_BEEF, `addr`=0x8000_0100 → `mreq` `is_write`=1 with identical fields; `dresp.data_ok` in the `ready` cycle.
- **Stale fetch:** ireq `addr` changes from 0x8000_0000 to 0x8000_0040 while SERVE_I → no `iresp.data_ok` for the old completion. The next grant latches 0x8000_0040.
- **Watchdog:** TIMEOUT=8, `ready` held 0 → `err_timeout` rises after 8 SERVE cycles and stays high after a later `ready`; `data_ok` is still delivered.
- **Reset mid-op:** reset in the 2nd SERVE_D cycle → next cycle `mreq.valid`=0, `busy`=0, `err_timeout`=0, no `data_ok`.
